// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
// Purpose : bundles the fetch handshake, the downstream stall and every
//           registered control output of control_sequencer into one port.
// Signals :
//   instr / instr_valid / instr_ready : one instruction word per handshake
//   stall                             : downstream hold, freezes the sequencer
//   read_reg1 / read_reg2 / write_reg : register-file selects
//   wb_sel / alu_b_sel / alu_op       : write-back source, ALU operand 2, ALU op
//   branch_sel                        : next-PC source, 0 = PC+1
//   reg_write_en / mem_read_en /
//   mem_write_en / mem_write_sel      : enables (only with ctrl_valid), store addr
//   ctrl_valid                        : one pulse per issued control beat
//   halted / illegal_op               : sticky halt, undefined-opcode pulse
// Modports: master = fetch/downstream side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int INSTR_W   = 10,
  parameter int REG_SEL_W = 4
);
  logic [INSTR_W-1:0]   instr;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 stall;
  logic [REG_SEL_W-1:0] read_reg1;
  logic [REG_SEL_W-1:0] read_reg2;
  logic [REG_SEL_W-1:0] write_reg;
  logic [2:0]           wb_sel;
  logic [2:0]           alu_b_sel;
  logic [1:0]           alu_op;
  logic [2:0]           branch_sel;
  logic                 reg_write_en;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [1:0]           mem_write_sel;
  logic                 ctrl_valid;
  logic                 halted;
  logic                 illegal_op;

  modport master (
    output instr, instr_valid, stall,
    input  instr_ready, read_reg1, read_reg2, write_reg, wb_sel, alu_b_sel,
           alu_op, branch_sel, reg_write_en, mem_read_en, mem_write_en,
           mem_write_sel, ctrl_valid, halted, illegal_op
  );

  modport slave (
    input  instr, instr_valid, stall,
    output instr_ready, read_reg1, read_reg2, write_reg, wb_sel, alu_b_sel,
           alu_op, branch_sel, reg_write_en, mem_read_en, mem_write_en,
           mem_write_sel, ctrl_valid, halted, illegal_op
  );
endinterface

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Purpose : registered, multi-cycle opcode decoder for the 10-bit processor.
//           Accepts one instruction per handshake, emits registered control
//           beats, and sequences memory reads (compare/pop), the two-beat push
//           and the sticky halt on its own.
// Ports   :
//   i_clk   : clock, all state on the rising edge
//   i_reset : synchronous active-high reset
//   io_bus  : control_sequencer_if.slave (fetch handshake, stall, controls)
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int INSTR_W   = 10,
  parameter int OPCODE_W  = 4,
  parameter int REG_SEL_W = 4,
  parameter int MEM_LAT   = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  control_sequencer_if.slave  io_bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef logic [REG_SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_PUSH_SP  = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  // One control beat: every select and enable that a beat drives.
  typedef struct packed {
    sel_t       rr1;
    sel_t       rr2;
    sel_t       wr;
    logic [2:0] wb_sel;
    logic [2:0] alu_b_sel;
    logic [2:0] branch_sel;
    logic [1:0] alu_op;
    logic [1:0] mem_write_sel;
    logic       reg_write_en;
    logic       mem_read_en;
    logic       mem_write_en;
  } beat_t;

  // Instruction fields
  logic [OPCODE_W-1:0] w_op;
  logic [4:0]          w_field;
  logic                w_bit0;
  logic [1:0]          w_low2;

  // Decoded first beat and follow-on behaviour of the presented instruction
  beat_t  w_dec;
  state_t w_dec_state;
  logic   w_dec_ill;
  logic   w_dec_pop;

  // Second beats of the multi-beat sequences
  beat_t  w_wb_beat;
  beat_t  w_push_beat;

  // Sequencer state and registered outputs
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_pop;
  beat_t            r_beat;
  logic             r_ctrl_valid;
  logic             r_halted;
  logic             r_illegal_op;

  assign w_op    = io_bus.instr[INSTR_W-1 -: OPCODE_W];
  assign w_field = io_bus.instr[5:1];
  assign w_bit0  = io_bus.instr[0];
  assign w_low2  = io_bus.instr[1:0];

  // Ready is the only combinational output: it must drop in the same cycle as
  // a stall or reset so fetch never hands over a word that would be lost.
  assign io_bus.instr_ready = (r_state == S_IDLE) & ~io_bus.stall & ~i_reset;

  assign io_bus.read_reg1     = r_beat.rr1;
  assign io_bus.read_reg2     = r_beat.rr2;
  assign io_bus.write_reg     = r_beat.wr;
  assign io_bus.wb_sel        = r_beat.wb_sel;
  assign io_bus.alu_b_sel     = r_beat.alu_b_sel;
  assign io_bus.alu_op        = r_beat.alu_op;
  assign io_bus.branch_sel    = r_beat.branch_sel;
  assign io_bus.reg_write_en  = r_beat.reg_write_en;
  assign io_bus.mem_read_en   = r_beat.mem_read_en;
  assign io_bus.mem_write_en  = r_beat.mem_write_en;
  assign io_bus.mem_write_sel = r_beat.mem_write_sel;
  assign io_bus.ctrl_valid    = r_ctrl_valid;
  assign io_bus.halted        = r_halted;
  assign io_bus.illegal_op    = r_illegal_op;

  // Decode the presented instruction into its first beat and the state it leads to
  always_comb begin
    w_dec       = '0;
    w_dec_state = S_IDLE;
    w_dec_ill   = 1'b0;
    w_dec_pop   = 1'b0;
    case (w_op)
      4'd0: begin  // result: store to frame by default, field picks a variant
        w_dec.rr1           = sel_t'(4'd3);
        w_dec.rr2           = sel_t'(4'd3);
        w_dec.wr            = sel_t'(4'd10);
        w_dec.mem_write_sel = 2'd2;
        case (w_field)
          5'd0: begin
            w_dec.mem_write_en = 1'b1;
          end
          5'd1: begin
            w_dec.mem_write_en = 1'b1;
            w_dec.alu_b_sel    = 3'd3;
            w_dec.reg_write_en = 1'b1;
          end
          5'd2: begin
            w_dec.mem_write_en = 1'b1;
            w_dec.alu_b_sel    = 3'd4;
            w_dec.reg_write_en = 1'b1;
          end
          5'd3: begin
            w_dec.mem_write_en = 1'b1;
            w_dec.wb_sel       = 3'd5;
            w_dec.reg_write_en = 1'b1;
          end
          5'd4: begin
            w_dec_state = S_HALT;
          end
          default: begin
            // Undefined field: selects issued, no enables.
            w_dec.mem_write_en = 1'b0;
          end
        endcase
      end
      4'd1: begin  // setImm
        w_dec.wb_sel       = 3'd7;
        w_dec.reg_write_en = 1'b1;
      end
      4'd2: begin  // loadQuery
        w_dec.wr           = sel_t'(4'd5);
        w_dec.wb_sel       = 3'd1;
        w_dec.reg_write_en = 1'b1;
      end
      4'd3: begin  // compare: read beat, write-back follows after MEM_LAT
        w_dec.rr1         = sel_t'(4'd3);
        w_dec.rr2         = sel_t'(4'd2);
        w_dec.mem_read_en = 1'b1;
        w_dec_state       = S_MEM_WAIT;
      end
      4'd4: begin  // jumpBackOrInit
        w_dec.wr     = sel_t'(4'd4);
        w_dec.wb_sel = 3'd3;
        case (w_field)
          5'd0:    w_dec.reg_write_en = 1'b1;
          5'd1:    w_dec.branch_sel   = 3'd2;
          5'd2:    w_dec.branch_sel   = 3'd3;
          default: w_dec.reg_write_en = 1'b0;
        endcase
      end
      4'd5: begin  // increment / decrement selected by the low bits
        w_dec.alu_b_sel    = 3'd2;
        w_dec.reg_write_en = 1'b1;
        w_dec.alu_op       = (w_low2 != 2'd0) ? 2'd1 : 2'd0;
      end
      4'd6: begin  // ifDone
        w_dec.rr1        = sel_t'(4'd3);
        w_dec.alu_b_sel  = 3'd5;
        w_dec.branch_sel = 3'd4;
      end
      4'd7: begin  // storeToZero
        w_dec.mem_write_en  = 1'b1;
        w_dec.mem_write_sel = 2'd1;
      end
      4'd8: begin  // setArg
        w_dec.wr           = sel_t'(4'd6 + {3'd0, w_bit0});
        w_dec.reg_write_en = 1'b1;
      end
      4'd9: begin  // jumpOrInitFp
        w_dec.reg_write_en = 1'b1;
        if (w_bit0) begin
          w_dec.wr     = sel_t'(4'd2);
          w_dec.wb_sel = 3'd4;
        end else begin
          w_dec.wr         = sel_t'(4'd1);
          w_dec.wb_sel     = 3'd7;
          w_dec.branch_sel = 3'd1;
        end
      end
      4'd10: begin  // skipIfNotOne
        w_dec.rr1        = sel_t'(4'd4 + {3'd0, w_bit0});
        w_dec.branch_sel = 3'd1;
        w_dec.alu_op     = 2'd1;
      end
      4'd11: begin  // push: store beat now, stack-pointer update next
        w_dec.rr1           = sel_t'(4'd2);
        w_dec.mem_write_en  = 1'b1;
        w_dec.mem_write_sel = 2'd1;
        w_dec.branch_sel    = 3'd4;
        w_dec_state         = S_PUSH_SP;
      end
      4'd12: begin  // pop: read beat, write-back follows after MEM_LAT
        w_dec.rr1         = sel_t'(4'd2);
        w_dec.mem_read_en = 1'b1;
        w_dec_state       = S_MEM_WAIT;
        w_dec_pop         = 1'b1;
      end
      4'd13: begin  // setTemp
        w_dec.wr           = sel_t'(4'd8 + {3'd0, w_bit0});
        w_dec.reg_write_en = 1'b1;
      end
      4'd14: begin  // return
        w_dec.rr1          = sel_t'(4'd6);
        w_dec.rr2          = sel_t'(4'd4);
        w_dec.wr           = sel_t'(4'd3);
        w_dec.reg_write_en = 1'b1;
        w_dec.alu_b_sel    = io_bus.instr[1] ? 3'd1 : 3'd6;
      end
      default: begin  // opcode 15 and anything undefined
        w_dec_ill = 1'b1;
      end
    endcase
  end

  // Contents of the write-back beat (memory reads) and the stack-pointer beat (push)
  always_comb begin
    w_wb_beat              = '0;
    w_wb_beat.wb_sel       = 3'd2;
    w_wb_beat.reg_write_en = 1'b1;
    if (r_is_pop) begin
      w_wb_beat.wr = sel_t'(4'd0);
    end else begin
      w_wb_beat.wr         = sel_t'(4'd11);
      w_wb_beat.branch_sel = 3'd5;
    end
    w_push_beat              = '0;
    w_push_beat.wr           = sel_t'(4'd2);
    w_push_beat.alu_b_sel    = 3'd2;
    w_push_beat.alu_op       = 2'd1;
    w_push_beat.reg_write_en = 1'b1;
  end

  // Sequencer FSM with registered control outputs; a stall freezes everything
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_pop     <= 1'b0;
      r_beat       <= '0;
      r_ctrl_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_illegal_op <= 1'b0;
    end else if (!io_bus.stall) begin
      // Non-beat cycles drop the pulse and enables; selects keep their value.
      r_ctrl_valid        <= 1'b0;
      r_illegal_op        <= 1'b0;
      r_beat.reg_write_en <= 1'b0;
      r_beat.mem_read_en  <= 1'b0;
      r_beat.mem_write_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // In IDLE without stall or reset, ready is high, so valid means accept.
          if (io_bus.instr_valid) begin
            if (w_dec_ill) begin
              r_illegal_op <= 1'b1;
            end else begin
              r_beat       <= w_dec;
              r_ctrl_valid <= 1'b1;
            end
            r_state  <= w_dec_state;
            r_is_pop <= w_dec_pop;
            if (w_dec_state == S_MEM_WAIT) begin
              r_cnt <= CNT_W'(MEM_LAT);
            end
            if (w_dec_state == S_HALT) begin
              r_halted <= 1'b1;
            end
          end
        end
        S_MEM_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Last wait cycle: read data is available, issue the write-back.
          if (r_cnt == CNT_W'(1)) begin
            r_beat       <= w_wb_beat;
            r_ctrl_valid <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_PUSH_SP: begin
          r_beat       <= w_push_beat;
          r_ctrl_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int LAT = 3;

  logic clk;
  logic rst;

  control_sequencer_if #(.INSTR_W(10), .REG_SEL_W(4)) bus_if ();

  control_sequencer #(
    .INSTR_W(10), .OPCODE_W(4), .REG_SEL_W(4), .MEM_LAT(LAT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: each instruction becomes a script ----
  typedef struct packed {
    logic [3:0] rr1, rr2, wr;
    logic [2:0] wb, ab, br;
    logic [1:0] aop, mws;
    logic       rwe, mre, mwe;
  } beat_s;

  typedef struct packed {
    logic  beat;   // 1 = issue b this cycle, 0 = idle gap inside a sequence
    beat_s b;
  } item_t;

  item_t q[$];
  beat_s m_out;
  logic  m_cv, m_ill, m_halted;
  logic  m_halt_req, m_ill_req;
  item_t it;

  function automatic beat_s mk(input int rr1, rr2, wr, wb, ab, br, aop, mws, rwe, mre, mwe);
    beat_s b;
    b.rr1 = rr1[3:0]; b.rr2 = rr2[3:0]; b.wr = wr[3:0];
    b.wb = wb[2:0]; b.ab = ab[2:0]; b.br = br[2:0];
    b.aop = aop[1:0]; b.mws = mws[1:0];
    b.rwe = rwe[0]; b.mre = mre[0]; b.mwe = mwe[0];
    return b;
  endfunction

  function automatic item_t bt(input beat_s b);
    item_t r;
    r.beat = 1'b1; r.b = b;
    return r;
  endfunction

  function automatic item_t gap();
    item_t r;
    r.beat = 1'b0; r.b = '0;
    return r;
  endfunction

  function automatic logic [9:0] ins(input int op, input int field, input int b0);
    logic [9:0] r;
    r = {op[3:0], field[4:0], b0[0]};
    return r;
  endfunction

  // Opcode table: the beats (and gaps) that one instruction must produce.
  task automatic expand(input logic [9:0] w);
    int op, f, b0, l2;
    op = int'(w[9:6]); f = int'(w[5:1]); b0 = int'(w[0]); l2 = int'(w[1:0]);
    case (op)
      0: begin
        if (f == 0)      q.push_back(bt(mk(3,3,10,0,0,0,0,2,0,0,1)));
        else if (f == 1) q.push_back(bt(mk(3,3,10,0,3,0,0,2,1,0,1)));
        else if (f == 2) q.push_back(bt(mk(3,3,10,0,4,0,0,2,1,0,1)));
        else if (f == 3) q.push_back(bt(mk(3,3,10,5,0,0,0,2,1,0,1)));
        else begin
          q.push_back(bt(mk(3,3,10,0,0,0,0,2,0,0,0)));
          if (f == 4) m_halt_req = 1'b1;
        end
      end
      1:  q.push_back(bt(mk(0,0,0,7,0,0,0,0,1,0,0)));
      2:  q.push_back(bt(mk(0,0,5,1,0,0,0,0,1,0,0)));
      3: begin
        q.push_back(bt(mk(3,2,0,0,0,0,0,0,0,1,0)));
        for (int k = 0; k < LAT - 1; k++) q.push_back(gap());
        q.push_back(bt(mk(0,0,11,2,0,5,0,0,1,0,0)));
      end
      4: begin
        if (f == 0)      q.push_back(bt(mk(0,0,4,3,0,0,0,0,1,0,0)));
        else if (f == 1) q.push_back(bt(mk(0,0,4,3,0,2,0,0,0,0,0)));
        else if (f == 2) q.push_back(bt(mk(0,0,4,3,0,3,0,0,0,0,0)));
        else             q.push_back(bt(mk(0,0,4,3,0,0,0,0,0,0,0)));
      end
      5:  q.push_back(bt(mk(0,0,0,0,2,0,(l2 != 0) ? 1 : 0,0,1,0,0)));
      6:  q.push_back(bt(mk(3,0,0,0,5,4,0,0,0,0,0)));
      7:  q.push_back(bt(mk(0,0,0,0,0,0,0,1,0,0,1)));
      8:  q.push_back(bt(mk(0,0,6+b0,0,0,0,0,0,1,0,0)));
      9: begin
        if (b0 == 0) q.push_back(bt(mk(0,0,1,7,0,1,0,0,1,0,0)));
        else         q.push_back(bt(mk(0,0,2,4,0,0,0,0,1,0,0)));
      end
      10: q.push_back(bt(mk(4+b0,0,0,0,0,1,1,0,0,0,0)));
      11: begin
        q.push_back(bt(mk(2,0,0,0,0,4,0,1,0,0,1)));
        q.push_back(bt(mk(0,0,2,0,2,0,1,0,1,0,0)));
      end
      12: begin
        q.push_back(bt(mk(2,0,0,0,0,0,0,0,0,1,0)));
        for (int k = 0; k < LAT - 1; k++) q.push_back(gap());
        q.push_back(bt(mk(0,0,0,2,0,0,0,0,1,0,0)));
      end
      13: q.push_back(bt(mk(0,0,8+b0,0,0,0,0,0,1,0,0)));
      14: q.push_back(bt(mk(6,4,3,0,w[1] ? 1 : 6,0,0,0,1,0,0)));
      default: m_ill_req = 1'b1;
    endcase
  endtask

  // Model advance on each rising edge, from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_out = '0; m_cv = 1'b0; m_ill = 1'b0; m_halted = 1'b0;
      q.delete();
    end else if (!bus_if.stall) begin
      m_cv = 1'b0; m_ill = 1'b0;
      m_out.rwe = 1'b0; m_out.mre = 1'b0; m_out.mwe = 1'b0;
      if (q.size() == 0 && !m_halted && bus_if.instr_valid) begin
        m_halt_req = 1'b0; m_ill_req = 1'b0;
        expand(bus_if.instr);
        if (m_ill_req)  m_ill = 1'b1;
        if (m_halt_req) m_halted = 1'b1;
      end
      if (q.size() > 0) begin
        it = q.pop_front();
        if (it.beat) begin
          m_out = it.b;
          m_cv  = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("beat",
          {3'd0, bus_if.read_reg1, bus_if.read_reg2, bus_if.write_reg, bus_if.wb_sel,
           bus_if.alu_b_sel, bus_if.branch_sel, bus_if.alu_op, bus_if.mem_write_sel,
           bus_if.reg_write_en, bus_if.mem_read_en, bus_if.mem_write_en, bus_if.ctrl_valid},
          {3'd0, m_out, m_cv});
      chk("status", {bus_if.halted, bus_if.illegal_op}, {m_halted, m_ill});
      chk("ready", bus_if.instr_ready,
          (q.size() == 0) && !m_halted && !bus_if.stall && !rst);
    end
  end

  // ---------------- directed stimulus with literal expectations -------------
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [9:0] tbl[$];

  initial begin
    rst = 1'b1;
    bus_if.instr_valid = 1'b0;
    bus_if.stall = 1'b0;
    bus_if.instr = '0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_cv", bus_if.ctrl_valid, 0);
    chk("rst_ready", bus_if.instr_ready, 0);
    chk("rst_halted", bus_if.halted, 0);
    chk("rst_wr", bus_if.write_reg, 0);
    rst = 1'b0;
    cyc(1);
    chk("idle_ready", bus_if.instr_ready, 1);

    // setImm with valid held, then loadQuery accepted on the very next edge
    bus_if.instr = ins(1,0,0); bus_if.instr_valid = 1'b1;
    cyc(1);
    chk("setimm_cv", bus_if.ctrl_valid, 1);
    chk("setimm_wb", bus_if.wb_sel, 7);
    chk("setimm_rwe", bus_if.reg_write_en, 1);
    chk("setimm_ready", bus_if.instr_ready, 1);
    bus_if.instr = ins(2,0,0);
    cyc(1);
    chk("loadq_wr", bus_if.write_reg, 5);
    chk("loadq_wb", bus_if.wb_sel, 1);

    // back-to-back single-beat ops, checked by the model every cycle
    tbl = '{ins(0,0,0), ins(0,1,0), ins(0,2,1), ins(0,3,0), ins(0,9,0),
            ins(4,0,0), ins(4,1,0), ins(4,2,0), ins(4,7,1), ins(5,0,0),
            ins(5,0,1), ins(5,1,0), ins(6,0,0), ins(7,0,0), ins(8,0,0),
            ins(9,0,0), ins(9,0,1), ins(10,0,0), ins(10,0,1), ins(13,0,1),
            ins(14,0,0), ins(14,1,0), ins(14,0,1)};
    foreach (tbl[i]) begin
      bus_if.instr = tbl[i];
      cyc(1);
    end

    bus_if.instr = ins(8,0,1);
    cyc(1);
    chk("setarg_wr", bus_if.write_reg, 7);
    bus_if.instr = ins(15,0,0);
    cyc(1);
    chk("illegal_pulse", bus_if.illegal_op, 1);
    chk("illegal_cv", bus_if.ctrl_valid, 0);
    chk("illegal_hold_wr", bus_if.write_reg, 7);
    bus_if.instr = ins(13,0,0);
    cyc(1);
    chk("settemp_wr", bus_if.write_reg, 8);
    bus_if.instr_valid = 1'b0;
    cyc(1);
    chk("idle_cv", bus_if.ctrl_valid, 0);
    chk("idle_hold_wr", bus_if.write_reg, 8);

    // pop: read beat, ready low for LAT cycles, write-back beat at accept+LAT+1
    bus_if.instr = ins(12,0,0); bus_if.instr_valid = 1'b1;
    cyc(1);
    bus_if.instr_valid = 1'b0;
    chk("pop_mre", bus_if.mem_read_en, 1);
    chk("pop_rr1", bus_if.read_reg1, 2);
    chk("pop_ready0", bus_if.instr_ready, 0);
    cyc(1);
    chk("pop_wait_cv", bus_if.ctrl_valid, 0);
    chk("pop_ready1", bus_if.instr_ready, 0);
    cyc(1);
    chk("pop_ready2", bus_if.instr_ready, 0);
    cyc(1);
    chk("pop_wb_cv", bus_if.ctrl_valid, 1);
    chk("pop_wb_sel", bus_if.wb_sel, 2);
    chk("pop_wb_rwe", bus_if.reg_write_en, 1);
    chk("pop_wb_ready", bus_if.instr_ready, 1);

    // compare with a one-cycle stall right after the read beat
    bus_if.instr = ins(3,0,0); bus_if.instr_valid = 1'b1;
    cyc(1);
    bus_if.instr_valid = 1'b0; bus_if.stall = 1'b1;
    cyc(1);
    chk("stall_hold_mre", bus_if.mem_read_en, 1);
    bus_if.stall = 1'b0;
    cyc(3);
    chk("cmp_wr", bus_if.write_reg, 11);
    chk("cmp_br", bus_if.branch_sel, 5);
    cyc(1);

    // stall while idle blocks acceptance
    bus_if.stall = 1'b1; bus_if.instr = ins(1,0,0); bus_if.instr_valid = 1'b1;
    cyc(2);
    chk("stall_idle_cv", bus_if.ctrl_valid, 0);
    bus_if.stall = 1'b0;
    cyc(1);
    chk("unstall_accept", bus_if.ctrl_valid, 1);

    // push with two stall cycles between the beats
    bus_if.instr = ins(11,0,0);
    cyc(1);
    bus_if.instr_valid = 1'b0;
    chk("push1_mwe", bus_if.mem_write_en, 1);
    chk("push1_br", bus_if.branch_sel, 4);
    bus_if.stall = 1'b1;
    cyc(2);
    chk("push_stall_cv", bus_if.ctrl_valid, 1);
    chk("push_stall_rwe", bus_if.reg_write_en, 0);
    bus_if.stall = 1'b0;
    cyc(1);
    chk("push2_aluop", bus_if.alu_op, 1);
    chk("push2_wr", bus_if.write_reg, 2);
    chk("push2_rwe", bus_if.reg_write_en, 1);
    chk("push2_mwe", bus_if.mem_write_en, 0);

    // reset in the middle of a memory wait abandons the write-back
    bus_if.instr = ins(12,0,0); bus_if.instr_valid = 1'b1;
    cyc(1);
    bus_if.instr_valid = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_outs",
        {bus_if.read_reg1, bus_if.write_reg, bus_if.wb_sel, bus_if.reg_write_en,
         bus_if.mem_read_en, bus_if.ctrl_valid}, 0);
    rst = 1'b0;
    cyc(4);
    chk("midrst_no_wb", bus_if.reg_write_en, 0);

    // halt: one pulse, ready stays low, only reset exits
    bus_if.instr = ins(0,4,0); bus_if.instr_valid = 1'b1;
    cyc(1);
    chk("halt_cv", bus_if.ctrl_valid, 1);
    chk("halt_flag", bus_if.halted, 1);
    chk("halt_mwe", bus_if.mem_write_en, 0);
    bus_if.instr = ins(1,0,0);
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("halt_ready", bus_if.instr_ready, 0);
    end
    rst = 1'b1;
    cyc(1);
    chk("halt_cleared", bus_if.halted, 0);
    rst = 1'b0; bus_if.instr_valid = 1'b0;
    cyc(1);
    chk("after_halt_ready", bus_if.instr_ready, 1);
    cyc(1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
